muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit: MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in EX and shares the operand buses.
- Holds the pipeline through hold_pipeline while an operation is in flight.
- Parametrised in data width and multiplier latency; adds RISC-V divide-by-zero and signed-overflow corner results.

Parameters:
- DATA_WIDTH, 32, operand/result width; even, >= 8
- MUL_LATENCY, 2, cycles from accept to result_valid for multiplies; >= 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  abort current op (branch/JALR redirect)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_A  input  DATA_WIDTH  rs1
- operand_B  input  DATA_WIDTH  rs2
- result  output  DATA_WIDTH  registered result; stable until the next accepted start
- result_valid  output  1  one-cycle pulse with a new result
- busy  output  1  high in MUL and DIV states
- hold_pipeline  output  1  combinational stall request to the hazard unit

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, result_valid=0, busy=0; internal counters/accumulators cleared.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1 (accept):
  - op[2]=0: latch operands, go to MUL, counter = MUL_LATENCY-1.
  - op[2]=1, operand_B=0: fast path to DONE.
    - DIV/DIVU: result = all ones.
    - REM/REMU: result = operand_A.
  - DIV/REM, operand_A = most negative, operand_B = -1: fast path to DONE.
    - DIV: result = operand_A.
    - REM: result = 0.
  - Otherwise go to DIV, counter = DATA_WIDTH-1.
- MUL:
  - Full 2*DATA_WIDTH product of the sign/zero-extended operands, per op.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low half; the MULH variants return the high half.
  - Counter decrements each cycle; at 0 go to DONE.
  - Latency: accept at cycle t -> result_valid at t+MUL_LATENCY+1.
- DIV:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle, DATA_WIDTH iterations.
  - Signed fix-up on exit: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Latency: accept at t -> result_valid at t+DATA_WIDTH+1.
  - Fast paths: result_valid at t+1.
- DONE:
  - result register written on entry; result_valid=1 for exactly this cycle.
  - Next state IDLE.
  - A start during DONE is ignored; it is re-sampled in IDLE next cycle.
- hold_pipeline = (start & state==IDLE) | busy. It is low in DONE, so the consumer captures result that cycle.
- start while busy or DONE is ignored; operands are captured only at accept.
- flush:
  - Any state -> IDLE next cycle.
  - No result_valid; result keeps its old value.
  - flush and start together in IDLE: flush wins, nothing is accepted.
- rst_n asserted mid-operation: immediate return to reset values; no pulse afterwards.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: on accept of a non-fast-path divide with |operand_A| < |operand_B| (unsigned magnitude compare), go directly to DONE.
  - Quotient = 0, remainder = operand_A.
  - result_valid at t+1.
- Undefined: such cases run the full DATA_WIDTH iterations with identical results.

Decomposition:
- muldiv_pkg holds:
  - op_e enum (8 funct3 codes) and state_e enum.
  - Helper function is_signed_a/is_signed_b(op).
- Natural sub-module: muldiv_div_core.
  - Holds the iterative restoring divider datapath: remainder/quotient shift registers and iteration counter.
  - Load/step/done interface; signed fix-up stays in muldiv_unit.

Test Plan:
- MUL 7 × -3 (MUL_LATENCY=2) -> result 0xFFFFFFEB, result_valid at t+3, hold_pipeline high t..t+2, low at t+3.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV -7 / 2 -> quotient 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; both result_valid at t+33.
- DIVU 5 / 0 -> 0xFFFFFFFF at t+1; REM 0x80000000 / -1 -> 0 at t+1; DIV 0x80000000 / -1 -> 0x80000000 at t+1.
- DIVU 100 / 7, flush at t+10 -> no result_valid, IDLE at t+11, result unchanged; a new start at t+12 is accepted.
- rst_n low mid-DIV -> busy/result_valid/result go to 0 immediately. With MULDIV_EARLY_OUT_EN: DIVU 3 / 9 -> 0 at t+1; without it: 0 at t+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_signed_a(op_e f);
    return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_signed_b(op_e f);
    return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic is_rem(op_e f);
    return (f == OP_REM) || (f == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quot_c,
  output logic [DATA_WIDTH-1:0] rem_c,
  output logic                  last_c
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [DW-1:0] rem_q;
  logic [DW-1:0] quot_q;
  logic [DW-1:0] dsr_q;
  logic [CW-1:0] cnt_q;
  logic [DW:0]   trial;

  // Next partial remainder/quotient; the top samples these on the final step.
  always_comb begin
    trial  = {rem_q, quot_q[DW-1]};
    rem_c  = trial[DW-1:0];
    quot_c = {quot_q[DW-2:0], 1'b0};
    if (trial >= {1'b0, dsr_q}) begin
      rem_c  = trial[DW-1:0] - dsr_q;
      quot_c = {quot_q[DW-2:0], 1'b1};
    end
    last_c = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dsr_q  <= divisor;
      cnt_q  <= CW'(DW - 1);
    end else if (step) begin
      rem_q  <= rem_c;
      quot_q <= quot_c;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide execute unit with pipeline hold.
// Optional macro MULDIV_EARLY_OUT_EN: finish divides with |A| < |B| on accept.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  hold_pipeline
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] result_q, result_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          capture, core_load, core_step;

  op_e           op_in, op_q;
  logic          sign_a, sign_b;
  logic [DW-1:0] mag_a, mag_b;
  logic          div_zero, div_ovf;
  logic [DW-1:0] a_q, b_q;
  logic          q_neg_q, r_neg_q;

  logic [2*DW-1:0] ext_a, ext_b, product;
  logic [DW-1:0]   mul_res, div_res;
  logic [DW-1:0]   core_quot, core_rem;
  logic            core_last;

  // Decode the incoming request: magnitudes and RISC-V corner cases.
  always_comb begin
    op_in    = op_e'(op);
    sign_a   = is_signed_a(op_in) & operand_A[DW-1];
    sign_b   = is_signed_b(op_in) & operand_B[DW-1];
    mag_a    = sign_a ? -operand_A : operand_A;
    mag_b    = sign_b ? -operand_B : operand_B;
    div_zero = (operand_B == '0);
    div_ovf  = op[2] & is_signed_b(op_in) & (operand_A == MIN_NEG) & (operand_B == '1);
  end

  // Product is modulo 2^(2*DW) of the extended operands, which equals the exact product.
  always_comb begin
    ext_a   = {{DW{is_signed_a(op_q) & a_q[DW-1]}}, a_q};
    ext_b   = {{DW{is_signed_b(op_q) & b_q[DW-1]}}, b_q};
    product = ext_a * ext_b;
    mul_res = (op_q == OP_MUL) ? product[DW-1:0] : product[2*DW-1:DW];
  end

  always_comb begin
    if (is_rem(op_q)) div_res = r_neg_q ? -core_rem : core_rem;
    else              div_res = q_neg_q ? -core_quot : core_quot;
  end

  muldiv_div_core #(.DATA_WIDTH(DW)) u_div_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .step     (core_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot_c   (core_quot),
    .rem_c    (core_rem),
    .last_c   (core_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    capture   = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && start) begin
          capture = 1'b1;
          if (!op[2]) begin
            state_d = ST_MUL;
            cnt_d   = CW'(MUL_LATENCY - 1);
          end else if (div_zero) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = is_rem(op_in) ? operand_A : '1;
          end else if (div_ovf) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = is_rem(op_in) ? '0 : operand_A;
`ifdef MULDIV_EARLY_OUT_EN
          end else if (mag_a < mag_b) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = is_rem(op_in) ? operand_A : '0;
`endif
          end else begin
            state_d   = ST_DIV;
            core_load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_DONE;
          valid_d  = 1'b1;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = div_res;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Operand and sign context captured only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (capture) begin
      a_q     <= operand_A;
      b_q     <= operand_B;
      op_q    <= op_in;
      q_neg_q <= sign_a ^ sign_b;
      r_neg_q <= sign_a;
    end
  end

  assign result        = result_q;
  assign result_valid  = valid_q;
  assign busy          = busy_q;
  assign hold_pipeline = (start && (state_q == ST_IDLE)) || busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned L  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [31:0]   operand_A = '0;
  logic [31:0]   operand_B = '0;
  logic [31:0]   result;
  logic          result_valid;
  logic          busy;
  logic          hold_pipeline;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  muldiv_unit #(.DATA_WIDTH(DW), .MUL_LATENCY(L)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .flush         (flush),
    .op            (op),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .hold_pipeline (hold_pipeline)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    p = '0;
    r = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit sgn;
    if (!f[2]) return L + 1;
    if (b == 0) return 1;
    sgn = (f == 3'd4) || (f == 3'd6);
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = {32'h0, a};
    mb = {32'h0, b};
    if (sgn && a[31]) ma = 64'h1_0000_0000 - ma;
    if (sgn && b[31]) mb = 64'h1_0000_0000 - mb;
`ifdef MULDIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return DW + 1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every result_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: actual result_valid=1 result=0x%08h required no pulse (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("latency", cyc, e.cyc);
        last_res = e.res;
      end
    end
  end

  // Waits for IDLE, presents one request for one cycle; optional ignored start the next cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it, input bit poke);
    int n;
    int t;
    exp_t e;
    n = 0;
    while ((busy || result_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: actual busy=%0b required 0 within 200 cycles", busy);
    end
    t = cyc;
    start = 1'b1;
    op = f;
    operand_A = a;
    operand_B = b;
    if (expect_it) begin
      e.res = model(f, a, b);
      e.cyc = t + latency(f, a, b);
      exp_q.push_back(e);
    end
    #1;
    check("hold_on_start", 32'(hold_pipeline), 32'd1);
    @(posedge clk);
    #1;
    if (poke) begin
      op = 3'($urandom);
      operand_A = $urandom;
      operand_B = $urandom;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold_pipeline), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 x -3 with hold_pipeline profile t..t+3
    issue(3'd0, 32'd7, -32'd3, 1'b1, 1'b0);
    check("mul_hold_t1", 32'(hold_pipeline), 32'd1);
    @(posedge clk); #1;
    check("mul_hold_t2", 32'(hold_pipeline), 32'd1);
    @(posedge clk); #1;
    check("mul_hold_t3", 32'(hold_pipeline), 32'd0);
    check("mul_valid_t3", 32'(result_valid), 32'd1);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(3'd4, -32'd7, 32'd2, 1'b1, 1'b0);
    check("div_busy", 32'(busy), 32'd1);
    issue(3'd6, -32'd7, 32'd2, 1'b1, 1'b0);
    issue(3'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(3'd5, 32'd3, 32'd9, 1'b1, 1'b0);

    // Flush DIVU 100/7 at t+10; new request at t+12
    issue(3'd5, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hold", 32'(hold_pipeline), 32'd0);
    check("flush_valid", 32'(result_valid), 32'd0);
    check("flush_result_kept", result, last_res);
    @(posedge clk);
    #1;
    issue(3'd0, 32'd12345, 32'd678, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a divide
    issue(3'd4, 32'h7654_3210, 32'd3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", result, 32'h0);
    last_res = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      issue(3'($urandom), rnd_operand(), rnd_operand(), 1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
